// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: checker state encoding, default 14-bit tap mask and
// the one-step Fibonacci LFSR advance used by both generator and checker.
package prbs_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  // x^14 + x^13 + x^12 + x^2 + 1
  localparam logic [13:0] PRBS14_TAPS = 14'h3802;

  // Shift left by one and append parity of the tapped bits; width <= 32.
  function automatic logic [31:0] lfsr_next(input logic [31:0] state,
                                            input logic [31:0] taps,
                                            input int          width);
    logic [31:0] mask;
    mask = (32'd1 << width) - 32'd1;
    return ((state << 1) | {31'd0, ^(state & taps)}) & mask;
  endfunction

endpackage

// File: rtl/prbs_popcount.sv
// Combinational population count of an N-bit word.
module prbs_popcount #(
  parameter int N  = 14,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  i_word,
  output logic [CW-1:0] o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < N; i++) begin
      o_count = o_count + CW'(i_word[i]);
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS word checker: SEARCH -> VERIFY -> LOCKED with a
// saturating error counter. Define PRBS_BITERR_EN to count bit errors instead of word errors.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int           N        = 14,
  parameter logic [N-1:0] TAPS     = PRBS14_TAPS,
  parameter int           LOCK_THR = 8,
  parameter int           LOSS_THR = 4,
  parameter int           CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     din,
  input  logic             din_vld,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       o_dbg_state
);

  localparam int MW = $clog2(LOCK_THR + 1);
  localparam int LW = $clog2(LOSS_THR + 1);
  localparam int PW = $clog2(N + 1);
  localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  chk_state_t       r_state;
  logic [N-1:0]     r_exp;
  logic [MW-1:0]    r_match;
  logic [LW-1:0]    r_miss;
  logic             r_locked;
  logic             r_err;
  logic [CNT_W-1:0] r_err_cnt;

  logic [N-1:0]     w_next_din;
  logic [N-1:0]     w_next_exp;
  logic             w_mismatch;
  logic             w_err_word;
  logic [SW-1:0]    w_inc;
  logic [SW-1:0]    w_sum;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_next_din = N'(lfsr_next(32'(din), 32'(TAPS), N));
  assign w_next_exp = N'(lfsr_next(32'(r_exp), 32'(TAPS), N));
  assign w_mismatch = (din != r_exp);
  assign w_err_word = din_vld && (r_state == LOCKED) && w_mismatch;

`ifdef PRBS_BITERR_EN
  logic [PW-1:0] w_popcnt;

  prbs_popcount #(.N(N), .CW(PW)) u_popcount (
    .i_word  (din ^ r_exp),
    .o_count (w_popcnt)
  );

  assign w_inc = SW'(w_popcnt);
`else
  assign w_inc = SW'(1);
`endif

  // Extra headroom bit lets saturation be a simple compare.
  assign w_sum      = SW'(r_err_cnt) + w_inc;
  assign w_cnt_next = (w_sum > SW'(CNT_MAX)) ? CNT_MAX : w_sum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= SEARCH;
      r_exp     <= '0;
      r_match   <= '0;
      r_miss    <= '0;
      r_locked  <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_err <= w_err_word;
      if (clr_cnt) begin
        r_err_cnt <= '0;
      end else if (w_err_word) begin
        r_err_cnt <= w_cnt_next;
      end
      if (din_vld) begin
        unique case (r_state)
          SEARCH: begin
            // An all-zero word is the LFSR lock-up state and cannot seed.
            if (din != '0) begin
              r_exp   <= w_next_din;
              r_match <= '0;
              r_state <= VERIFY;
            end
          end
          VERIFY: begin
            if (!w_mismatch) begin
              r_exp   <= w_next_din;
              r_match <= r_match + 1'b1;
              if (r_match == MW'(LOCK_THR - 1)) begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
                r_miss   <= '0;
              end
            end else if (din != '0) begin
              r_exp   <= w_next_din;
              r_match <= '0;
            end else begin
              r_state <= SEARCH;
            end
          end
          LOCKED: begin
            // Free-run the prediction so a corrupted word never reseeds it.
            r_exp <= w_next_exp;
            if (w_mismatch) begin
              r_miss <= r_miss + 1'b1;
              if (r_miss == LW'(LOSS_THR - 1)) begin
                r_state  <= SEARCH;
                r_locked <= 1'b0;
              end
            end else begin
              r_miss <= '0;
            end
          end
          default: r_state <= SEARCH;
        endcase
      end
    end
  end

  assign locked      = r_locked;
  assign err         = r_err;
  assign err_cnt     = r_err_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: directed table, hand-written corner sequences and
// random traffic against a word-level reference model; two DUTs (16- and 4-bit counters).
module tb_prbs_checker;

  localparam int LOCK_THR = 8;
  localparam int LOSS_THR = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] din;
  logic        din_vld;
  logic        clr_cnt;

  logic        locked, err;
  logic [15:0] err_cnt;
  logic [1:0]  dbg_state;
  logic        locked4, err4;
  logic [3:0]  err_cnt4;
  logic [1:0]  dbg_state4;

  int total = 0;
  int bad   = 0;

  logic [21:0] exp_q[$];

  // reference model variables
  int          m_mode;
  logic [13:0] m_pred;
  int          m_good, m_bad, m_c16, m_c4;
  bit          m_err;

  logic [13:0] gen_s;

  typedef struct {
    bit          rst_n;
    bit          vld;
    logic [13:0] din;
    bit          clr;
    bit          locked;
    bit          err;
    logic [15:0] cnt;
  } vec_t;
  vec_t vecs[17];

  prbs_checker #(.N(14), .LOCK_THR(LOCK_THR), .LOSS_THR(LOSS_THR), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .clr_cnt(clr_cnt),
    .locked(locked), .err(err), .err_cnt(err_cnt), .o_dbg_state(dbg_state)
  );

  prbs_checker #(.N(14), .LOCK_THR(LOCK_THR), .LOSS_THR(LOSS_THR), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .clr_cnt(clr_cnt),
    .locked(locked4), .err(err4), .err_cnt(err_cnt4), .o_dbg_state(dbg_state4)
  );

  // clock
  always #5 clk = ~clk;

  // x^14 + x^13 + x^12 + x^2 + 1 stepped directly from the polynomial
  function automatic logic [13:0] nxt(input logic [13:0] s);
    return {s[12:0], s[13] ^ s[12] ^ s[11] ^ s[1]};
  endfunction

  function automatic int sat_add(input int a, input int b, input int max);
    return (a + b > max) ? max : a + b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Word-level reference: counts good words since seeding and bad words since lock.
  task automatic model_step(input bit r, input bit v, input logic [13:0] d, input bit c);
    int inc;
    inc = 0;
    if (!r) begin
      m_mode = 0; m_pred = '0; m_good = 0; m_bad = 0;
      m_c16 = 0; m_c4 = 0; m_err = 0;
    end else begin
      m_err = 0;
      if (v) begin
        if (m_mode == 0) begin
          if (d != 0) begin m_pred = nxt(d); m_good = 0; m_mode = 1; end
        end else if (m_mode == 1) begin
          if (d == m_pred) begin
            m_good++;
            m_pred = nxt(d);
            if (m_good == LOCK_THR) begin m_mode = 2; m_bad = 0; end
          end else if (d != 0) begin
            m_pred = nxt(d); m_good = 0;
          end else begin
            m_mode = 0;
          end
        end else begin
          if (d != m_pred) begin
            m_err = 1;
`ifdef PRBS_BITERR_EN
            inc = $countones(d ^ m_pred);
`else
            inc = 1;
`endif
            m_bad++;
            if (m_bad == LOSS_THR) m_mode = 0;
          end else begin
            m_bad = 0;
          end
          m_pred = nxt(m_pred);
        end
      end
      if (c) begin
        m_c16 = 0; m_c4 = 0;
      end else begin
        m_c16 = sat_add(m_c16, inc, 65535);
        m_c4  = sat_add(m_c4, inc, 15);
      end
    end
    exp_q.push_back({(m_mode == 2), m_err, m_c16[15:0], m_c4[3:0]});
  endtask

  // driver: one clock per call, outputs compared 1 ns after the edge
  task automatic apply(input bit r, input bit v, input logic [13:0] d, input bit c);
    logic [21:0] e;
    rst = r; din_vld = v; din = d; clr_cnt = c;
    model_step(r, v, d, c);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("locked",   32'(locked),   32'(e[21]));
    check("err",      32'(err),      32'(e[20]));
    check("err_cnt",  32'(err_cnt),  32'(e[19:4]));
    check("err_cnt4", 32'(err_cnt4), 32'(e[3:0]));
  endtask

  task automatic send_clean();
    apply(1'b1, 1'b1, gen_s, 1'b0);
    gen_s = nxt(gen_s);
  endtask

  task automatic send_bad(input logic [13:0] flip, input bit c);
    apply(1'b1, 1'b1, gen_s ^ flip, c);
    gen_s = nxt(gen_s);
  endtask

  initial begin
    logic [13:0] ws[13];
    logic [13:0] mask;
    int          sel;

    rst = 1'b0; din_vld = 1'b0; din = '0; clr_cnt = 1'b0;

    ws[0] = 14'h0001;
    for (int i = 1; i < 13; i++) ws[i] = nxt(ws[i-1]);
    vecs[0] = '{1'b0, 1'b0, 14'h0000, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[1] = '{1'b0, 1'b0, 14'h0000, 1'b0, 1'b0, 1'b0, 16'd0};
    for (int k = 0; k < 9; k++)
      vecs[2+k] = '{1'b1, 1'b1, ws[k], 1'b0, (k == 8), 1'b0, 16'd0};
    vecs[11] = '{1'b1, 1'b1, ws[9] ^ 14'h0001, 1'b0, 1'b1, 1'b1, 16'd1};
    vecs[12] = '{1'b1, 1'b1, ws[10], 1'b0, 1'b1, 1'b0, 16'd1};
    vecs[13] = '{1'b1, 1'b0, 14'h3FFF, 1'b0, 1'b1, 1'b0, 16'd1};
    vecs[14] = '{1'b1, 1'b1, ws[11], 1'b0, 1'b1, 1'b0, 16'd1};
    vecs[15] = '{1'b0, 1'b1, ws[12], 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[16] = '{1'b1, 1'b0, 14'h0000, 1'b0, 1'b0, 1'b0, 16'd0};

    // reset, clean lock from seed 1, single-bit error, gap, reset while locked
    for (int i = 0; i < 17; i++) begin
      apply(vecs[i].rst_n, vecs[i].vld, vecs[i].din, vecs[i].clr);
      check($sformatf("tbl%0d_locked", i), 32'(locked), 32'(vecs[i].locked));
      check($sformatf("tbl%0d_err", i), 32'(err), 32'(vecs[i].err));
      check($sformatf("tbl%0d_cnt", i), 32'(err_cnt), 32'(vecs[i].cnt));
    end

    // lock, lose lock with 4 consecutive bad words, relock in 9
    gen_s = 14'h1ACE;
    for (int i = 0; i < 8; i++) send_clean();
    check("pre_lock", 32'(locked), 32'd0);
    send_clean();
    check("lock_9", 32'(locked), 32'd1);
    for (int k = 0; k < 4; k++) begin
      send_bad(14'h0001, 1'b0);
      check("loss_err", 32'(err), 32'd1);
      check("loss_locked", 32'(locked), (k < 3) ? 32'd1 : 32'd0);
    end
    check("loss_cnt", 32'(err_cnt), 32'd4);
    for (int i = 0; i < 8; i++) send_clean();
    check("relock_early", 32'(locked), 32'd0);
    send_clean();
    check("relock_9", 32'(locked), 32'd1);

    // reset mid-lock, then all-zero input never seeds
    apply(1'b0, 1'b0, 14'h0000, 1'b0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_cnt", 32'(err_cnt), 32'd0);
    for (int i = 0; i < 10; i++) apply(1'b1, 1'b1, 14'h0000, 1'b0);
    check("zero_search", 32'(locked), 32'd0);

    // valid gaps hold state during acquisition
    gen_s = 14'h2345;
    for (int i = 0; i < 8; i++) begin
      send_clean();
      if ($urandom_range(0, 1) == 1) apply(1'b1, 1'b0, 14'($urandom), 1'b0);
    end
    apply(1'b1, 1'b0, 14'($urandom), 1'b0);
    check("gap_not_locked", 32'(locked), 32'd0);
    send_clean();
    check("gap_locked", 32'(locked), 32'd1);

    // clear wins over simultaneous error; 20 errors saturate the 4-bit counter
    send_bad(14'h0001, 1'b1);
    check("clr_err", 32'(err), 32'd1);
    check("clr_cnt", 32'(err_cnt), 32'd0);
    for (int i = 0; i < 20; i++) begin
      send_bad(14'h0001, 1'b0);
      send_clean();
    end
    check("sat_cnt16", 32'(err_cnt), 32'd20);
    check("sat_cnt4", 32'(err_cnt4), 32'hF);
    check("sat_locked", 32'(locked), 32'd1);

    // three flipped bits in one word
    apply(1'b1, 1'b1, gen_s, 1'b1);
    gen_s = nxt(gen_s);
    send_bad(14'h0111, 1'b0);
    check("multi_err", 32'(err), 32'd1);
`ifdef PRBS_BITERR_EN
    check("multi_cnt", 32'(err_cnt), 32'd3);
`else
    check("multi_cnt", 32'(err_cnt), 32'd1);
`endif
    send_clean();
    check("multi_err_clear", 32'(err), 32'd0);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        apply(1'b0, 1'($urandom_range(0, 1)), 14'($urandom), 1'b0);
      end else if ($urandom_range(0, 3) == 0) begin
        apply(1'b1, 1'b0, 14'($urandom), 1'($urandom_range(0, 49) == 0));
      end else begin
        sel = $urandom_range(0, 99);
        if (sel < 85) begin
          apply(1'b1, 1'b1, gen_s, 1'($urandom_range(0, 49) == 0));
        end else if (sel < 93) begin
          mask = 14'($urandom_range(1, 16383));
          apply(1'b1, 1'b1, gen_s ^ mask, 1'($urandom_range(0, 49) == 0));
        end else if (sel < 96) begin
          apply(1'b1, 1'b1, 14'h0000, 1'b0);
        end else begin
          gen_s = 14'($urandom_range(1, 16383));
          apply(1'b1, 1'b1, gen_s, 1'b0);
        end
        gen_s = nxt(gen_s);
        if (gen_s == 14'h0000) gen_s = 14'h0001;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
